// File: rtl/soc_pio_out_fifo.sv
// Avalon-MM output PIO with two modes: DIRECT (output register with set/clear)
// and FIFO (CPU writes are queued and drained to the network over valid/ready).
// Latency: 1 clk from write to out_port; readdata is combinational from address.
// Backpressure: FIFO mode holds the head while out_ready is low; a push into a full
// FIFO without a same-cycle pop is dropped and raises sticky overflow.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata           Avalon-MM slave write side
//   readdata                     zero wait-state read data
//   out_port, out_valid          data to network (valid always 1 in DIRECT mode)
//   out_ready                    network accept
//   irq                          level interrupt = irq_en & overflow
module soc_pio_out_fifo #(
    parameter int                 DATA_W      = 32,
    parameter int                 DEPTH       = 8,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;

    logic [DATA_W-1:0] r_out_reg;
    logic              r_mode;
    logic              r_irq_en;
    logic              r_ovf;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    logic              w_wr;
    logic              w_data_wr;
    logic              w_stat_wr;
    logic              w_ctrl_wr;
    logic              w_set_wr;
    logic              w_clr_wr;
    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_ctrl;

    assign w_wr      = chipselect & ~write_n;
    assign w_data_wr = w_wr & (address == A_DATA);
    assign w_stat_wr = w_wr & (address == A_STATUS);
    assign w_ctrl_wr = w_wr & (address == A_CTRL);
    assign w_set_wr  = w_wr & (address == A_SET);
    assign w_clr_wr  = w_wr & (address == A_CLR);

    // Explicit flush bit, or any CONTROL write that changes the mode.
    assign w_flush = w_ctrl_wr & (writedata[1] | (writedata[0] != r_mode));

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // Push uses the mode in force before this edge.
    assign w_push    = w_data_wr & r_mode;
    assign w_pop     = r_mode & ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head retires on the same edge.
    assign w_push_ok = w_push & (~w_full | w_pop) & ~w_flush;
    // A push discarded by a flush is not an overflow.
    assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

    // Control / status / direct output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_reg <= RESET_VALUE;
            r_mode    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_mode   <= writedata[0];
                r_irq_en <= writedata[2];
            end
            if (!r_mode) begin
                if (w_data_wr)
                    r_out_reg <= writedata;
                else if (w_set_wr)
                    r_out_reg <= r_out_reg | writedata;
                else if (w_clr_wr)
                    r_out_reg <= r_out_reg & ~writedata;
            end
            // Set has priority over a same-edge write-1-to-clear.
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_stat_wr && writedata[2])
                r_ovf <= 1'b0;
        end
    end

    // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{(LW-1){1'b0}}, w_push_ok} - {{(LW-1){1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: entries are only visible while the level covers them.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= writedata;
    end

    assign out_port  = r_mode ? (w_empty ? RESET_VALUE : r_mem[r_rd_ptr]) : r_out_reg;
    assign out_valid = r_mode ? ~w_empty : 1'b1;
    assign irq       = r_irq_en & r_ovf;

    always_comb begin
        w_status          = '0;
        w_status[0]       = w_empty;
        w_status[1]       = w_full;
        w_status[2]       = r_ovf;
        w_status[LW+7:8]  = r_level;
        w_ctrl            = '0;
        w_ctrl[0]         = r_mode;
        w_ctrl[2]         = r_irq_en;
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata = out_port;
            A_STATUS: readdata = w_status;
            A_CTRL:   readdata = w_ctrl;
            default:  readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_pio_out_fifo.sv
module tb_soc_pio_out_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam logic [31:0] RV = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    soc_pio_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus write; returns #1 after the capturing edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_out;
    } vec_t;
    vec_t tbl [8];

    // Reference model for randomized FIFO traffic
    logic [31:0] q[$];
    logic        m_ovf;
    logic        m_irq_en;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(q.size()) << 8;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_ovf;
        return s;
    endfunction

    initial begin
        logic [31:0] rdv;
        logic [31:0] exp_q [8];

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset out_port", out_port, RV);
        check("reset out_valid", 32'(out_valid), 32'd1);
        check("reset irq", 32'(irq), 32'd0);
        rd(3'd1, rdv); check("reset STATUS", rdv, 32'h001);
        rd(3'd2, rdv); check("reset CONTROL", rdv, 32'h0);
        rd(3'd0, rdv); check("reset DATA read", rdv, RV);

        // ---------------- DIRECT mode table
        tbl[0] = '{3'd0, 32'h0000_00F0, 32'h0000_00F0};
        tbl[1] = '{3'd4, 32'h0000_000F, 32'h0000_00FF};
        tbl[2] = '{3'd5, 32'h0000_0030, 32'h0000_00CF};
        tbl[3] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_00CF};
        tbl[4] = '{3'd3, 32'h1234_5678, 32'h0000_00CF};
        tbl[5] = '{3'd0, 32'hAAAA_5555, 32'hAAAA_5555};
        tbl[6] = '{3'd4, 32'h0000_FFFF, 32'hAAAA_FFFF};
        tbl[7] = '{3'd5, 32'hFFFF_0000, 32'h0000_FFFF};
        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].addr, tbl[i].data);
            check($sformatf("direct[%0d] out_port", i), out_port, tbl[i].exp_out);
            check($sformatf("direct[%0d] out_valid", i), 32'(out_valid), 32'd1);
        end
        rd(3'd0, rdv); check("direct DATA read", rdv, 32'h0000_FFFF);

        // ---------------- FIFO fill, overflow, irq, W1C
        out_ready = 1'b0;
        wr(3'd2, 32'h5);
        check("fifo empty out_valid", 32'(out_valid), 32'd0);
        check("fifo empty out_port", out_port, RV);
        rd(3'd2, rdv); check("CONTROL readback", rdv, 32'h5);
        for (int i = 0; i < 8; i++) begin
            wr(3'd0, 32'h11 + 32'(i));
            if (i == 0) check("first push latency", out_port, 32'h11);
        end
        rd(3'd1, rdv); check("full STATUS", rdv, 32'h0802);
        check("full irq", 32'(irq), 32'd0);
        wr(3'd0, 32'h99);
        rd(3'd1, rdv); check("overflow STATUS", rdv, 32'h0806);
        check("overflow irq", 32'(irq), 32'd1);
        check("head after overflow", out_port, 32'h11);
        wr(3'd1, 32'h4);
        check("W1C irq", 32'(irq), 32'd0);
        rd(3'd1, rdv); check("W1C STATUS", rdv, 32'h0802);

        // ---------------- push + pop while full
        out_ready = 1'b1;
        wr(3'd0, 32'hAA);
        out_ready = 1'b0;
        rd(3'd1, rdv); check("push+pop full STATUS", rdv, 32'h0802);
        for (int i = 0; i < 7; i++) exp_q[i] = 32'h12 + 32'(i);
        exp_q[7] = 32'hAA;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain[%0d] out_port", i), out_port, exp_q[i]);
            check($sformatf("drain[%0d] out_valid", i), 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("drained out_valid", 32'(out_valid), 32'd0);
        check("drained out_port", out_port, RV);

        // ---------------- flush with a same-cycle pop
        wr(3'd0, 32'h21); wr(3'd0, 32'h22); wr(3'd0, 32'h23);
        rd(3'd1, rdv); check("3 entries STATUS", rdv, 32'h0300);
        out_ready = 1'b1;
        wr(3'd2, 32'h3);
        out_ready = 1'b0;
        rd(3'd1, rdv); check("flush STATUS", rdv, 32'h001);
        check("flush out_valid", 32'(out_valid), 32'd0);

        // ---------------- randomized FIFO traffic against a queue model
        q.delete(); m_ovf = 1'b0; m_irq_en = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int r;
            logic rdy, do_push, do_w1c, do_flush, pop, set, full_before;
            logic [31:0] d;
            @(negedge clk);
            check("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd out_port", out_port, (q.size() != 0) ? q[0] : RV);
            check("rnd irq", 32'(irq), 32'(m_irq_en & m_ovf));
            r = $urandom_range(0, 99);
            rdy = 1'($urandom_range(0, 1));
            d = $urandom;
            do_push = (r < 50); do_w1c = (r >= 50 && r < 60); do_flush = (r >= 60 && r < 65);
            out_ready = rdy;
            if (do_push) begin
                address = 3'd0; writedata = d; chipselect = 1'b1; write_n = 1'b0;
            end else if (do_w1c) begin
                address = 3'd1; writedata = d; chipselect = 1'b1; write_n = 1'b0;
            end else if (do_flush) begin
                d = {29'b0, d[2], 2'b11};
                address = 3'd2; writedata = d; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                address = 3'd1; chipselect = 1'b0; write_n = 1'b1;
                #1 check("rnd STATUS", readdata, model_status());
            end
            pop = (q.size() != 0) && rdy;
            set = 1'b0;
            if (do_flush) begin
                q.delete();
                m_irq_en = d[2];
            end else begin
                full_before = (q.size() == DEPTH);
                if (pop) void'(q.pop_front());
                if (do_push) begin
                    if (!full_before || pop) q.push_back(d);
                    else set = 1'b1;
                end
            end
            if (set) m_ovf = 1'b1;
            else if (do_w1c && d[2]) m_ovf = 1'b0;
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
        check("rnd final out_valid", 32'(out_valid), 32'(q.size() != 0));
        rd(3'd1, rdv); check("rnd final STATUS", rdv, model_status());

        // ---------------- mode change retains out_reg
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h0);
        check("back to DIRECT out_port", out_port, 32'h0000_FFFF);
        check("back to DIRECT out_valid", 32'(out_valid), 32'd1);

        // ---------------- async reset mid-transfer
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h31); wr(3'd0, 32'h32);
        rd(3'd1, rdv); check("pre-reset STATUS", rdv, 32'h0200);
        check("pre-reset out_port", out_port, 32'h31);
        #1 reset = 1'b1;
        #1;
        rd(3'd1, rdv); check("async reset STATUS", rdv, 32'h001);
        rd(3'd2, rdv); check("async reset CONTROL", rdv, 32'h0);
        check("async reset out_port", out_port, RV);
        check("async reset out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset out_port", out_port, RV);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
